// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice plus a carry flop, one result bit per clock.
// Optional subtract mode (a - b) is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [WIDTH-2:0] acc;
    logic [WIDTH-1:0] acc_full;
    logic [CW-1:0]    cnt;
    logic             c;
    logic             accept, last;
    logic             b0, bit_s, c_nxt, c_init;

`ifdef SERIAL_ADDER_SUB_EN
    logic inv_b;
    // Subtraction is a + ~b + 1: invert B on the fly and force the initial carry.
    assign b0     = b_sh[0] ^ inv_b;
    assign c_init = sub ? 1'b1 : cin;
`else
    assign b0     = b_sh[0];
    assign c_init = cin;
`endif

    assign last     = (cnt == LAST);
    assign bit_s    = a_sh[0] ^ b0 ^ c;
    assign c_nxt    = (a_sh[0] & b0) | (a_sh[0] & c) | (b0 & c);
    assign acc_full = {bit_s, acc};
    assign busy     = (state == RUN);
    assign done     = (state == DONE);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE, DONE: begin
                state_nxt = IDLE;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN:     if (last) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh <= '0;
            b_sh <= '0;
            acc  <= '0;
            cnt  <= '0;
            c    <= 1'b0;
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            inv_b <= 1'b0;
`endif
        end else if (accept) begin
            a_sh <= a;
            b_sh <= b;
            cnt  <= '0;
            c    <= c_init;
`ifdef SERIAL_ADDER_SUB_EN
            inv_b <= sub;
`endif
        end else if (state == RUN) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            acc  <= acc_full[WIDTH-1:1];
            cnt  <= cnt + CW'(1);
            c    <= c_nxt;
            // Visible result only moves on the edge entering DONE; c here is the carry into the MSB.
            if (last) begin
                sum  <= acc_full;
                cout <= c_nxt;
                ovf  <= c ^ c_nxt;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder: WIDTH=8 directed cases and a
// WIDTH=4 exhaustive back-to-back sweep, checked against a queue-based scoreboard.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } res8_t;

    typedef struct packed {
        logic [3:0] sum;
        logic       cout;
    } res4_t;

    logic       start8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] sum8;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub8 = 1'b0;
`endif

    logic       start4 = 1'b0, cin4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, cout4, ovf4;
    logic [3:0] sum4;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub4 = 1'b0;
`endif

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub8),
`endif
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub4),
`endif
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    int    checks = 0;
    int    errors = 0;
    int    cycle = 0;
    int    done4_cnt = 0;
    res8_t q8[$];
    res4_t q4[$];

    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (done4) done4_cnt <= done4_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic res8_t model8(input logic [7:0] ma, mb, input logic mc, ms);
        logic [7:0] bb;
        logic       cc;
        logic [8:0] full;
        res8_t      r;
        bb     = ms ? ~mb : mb;
        cc     = ms ? 1'b1 : mc;
        full   = {1'b0, ma} + {1'b0, bb} + {8'd0, cc};
        r.sum  = full[7:0];
        r.cout = full[8];
        r.ovf  = (ma[7] == bb[7]) && (full[7] != ma[7]);
        return r;
    endfunction

    // One full WIDTH=8 operation; optionally pulses start with different operands mid-RUN.
    task automatic run8(input string tag, input logic [7:0] ta, tb_, input logic tc, ts,
                        input bit glitch);
        logic [7:0] prev_sum;
        res8_t      e;
        @(negedge clk);
        a8 = ta; b8 = tb_; cin8 = tc; start8 = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
        sub8 = ts;
`endif
        prev_sum = sum8;
        @(posedge clk);
        q8.push_back(model8(ta, tb_, tc, ts));
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start8 = 1'b0;
            check({tag, "_busy"}, {62'd0, busy8, done8}, 64'd2);
            check({tag, "_hold"}, {56'd0, sum8}, {56'd0, prev_sum});
            if (glitch && (i == 2 || i == 5)) begin
                start8 = 1'b1; a8 = ~ta; b8 = ~tb_; cin8 = ~tc;
            end
        end
        @(negedge clk);
        check({tag, "_done"}, {62'd0, busy8, done8}, 64'd1);
        if (q8.size() != 0) begin
            e = q8.pop_front();
            check({tag, "_sum"}, {56'd0, sum8}, {56'd0, e.sum});
            check({tag, "_cout"}, {63'd0, cout8}, {63'd0, e.cout});
            check({tag, "_ovf"}, {63'd0, ovf8}, {63'd0, e.ovf});
        end
        @(negedge clk);
        check({tag, "_done_end"}, {62'd0, busy8, done8}, 64'd0);
    endtask

    initial begin
        res4_t e4;
        int    cyc, last_done, ndone;
        logic  seen;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset8", {52'd0, busy8, done8, sum8, cout8, ovf8}, 64'd0);
        check("reset4", {56'd0, busy4, done4, sum4, cout4, ovf4}, 64'd0);
        rst_n = 1'b1;

        run8("t5a3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
        run8("tff01", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        run8("tglitch", 8'h12, 8'h34, 1'b1, 1'b0, 1'b1);
        run8("t7f00", 8'h7F, 8'h00, 1'b1, 1'b0, 1'b0);

        // Reset mid-RUN, before bit 3 is processed
        @(negedge clk);
        a8 = 8'hA5; b8 = 8'h0F; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start8 = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("rst_mid", {52'd0, busy8, done8, sum8, cout8, ovf8}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done8 || busy8) seen = 1'b1;
        end
        check("rst_no_done", {63'd0, seen}, 64'd0);
        run8("tpost_rst", 8'hA5, 8'h0F, 1'b0, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        run8("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1, 1'b0);
        run8("sub_00_01", 8'h00, 8'h01, 1'b1, 1'b1, 1'b0);
        run8("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 1'b0);
        run8("add_sub0", 8'h80, 8'h01, 1'b1, 1'b0, 1'b0);
`endif

        // WIDTH=4 exhaustive, back-to-back with start raised in each done cycle
        last_done = -1;
        @(negedge clk);
        {a4, b4, cin4} = 9'd0;
        start4 = 1'b1;
        ndone = done4_cnt;
        for (int k = 0; k < 512; k++) begin
            logic [4:0] full;
            @(posedge clk);
            full = {1'b0, a4} + {1'b0, b4} + {4'd0, cin4};
            q4.push_back('{sum: full[3:0], cout: full[4]});
            @(negedge clk);
            start4 = 1'b0;
            cyc = 1;
            while (!done4 && cyc < 12) begin
                @(negedge clk);
                cyc++;
            end
            check("ex_latency", 64'(cyc), 64'd5);
            if (last_done >= 0) check("ex_gap", 64'(cycle - last_done), 64'd5);
            last_done = cycle;
            if (q4.size() != 0) begin
                e4 = q4.pop_front();
                check("ex_sum", {59'd0, sum4, cout4}, {59'd0, e4.sum, e4.cout});
            end
            if (k < 511) begin
                {a4, b4, cin4} = 9'(k + 1);
                start4 = 1'b1;
            end
        end
        repeat (8) @(negedge clk);
        check("ex_done_count", 64'(done4_cnt - ndone), 64'd512);
        check("queues_empty", 64'(q8.size() + q4.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
